// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 4-stage pipelined signed multiplier among N_REQ requesters.
// Optional output saturation and dout_sat port: define MULT_SHARE_ARBITER_SAT_EN.
module mult_share_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DIN1_WIDTH = 16,
  parameter int DIN2_WIDTH = 16,
  parameter int DOUT_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIN1_WIDTH*N_REQ-1:0]      req_din1,
  input  logic [DIN2_WIDTH*N_REQ-1:0]      req_din2,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  output logic signed [DOUT_WIDTH-1:0]     dout,
  output logic                             dout_valid,
  output logic [ID_WIDTH-1:0]              dout_id
`ifdef MULT_SHARE_ARBITER_SAT_EN
  ,
  output logic                             dout_sat
`endif
);

  localparam int P = DIN1_WIDTH + DIN2_WIDTH;

`ifdef MULT_SHARE_ARBITER_SAT_EN
  localparam int EW = (DOUT_WIDTH > P) ? DOUT_WIDTH : P;
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic signed [DOUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  function automatic logic sat_ovf(input logic signed [P-1:0] p);
    logic signed [EW-1:0] e;
    e = EW'(p);
    return (e > SAT_MAX) || (e < SAT_MIN);
  endfunction

  function automatic logic signed [DOUT_WIDTH-1:0] sat_result(input logic signed [P-1:0] p);
    logic signed [EW-1:0] e;
    e = EW'(p);
    if (e > SAT_MAX)      return OUT_MAX;
    else if (e < SAT_MIN) return OUT_MIN;
    else                  return DOUT_WIDTH'(p);
  endfunction
`else
  // Size cast sign-extends a wider output and keeps the low bits of a narrower one.
  function automatic logic signed [DOUT_WIDTH-1:0] wrap_result(input logic signed [P-1:0] p);
    return DOUT_WIDTH'(p);
  endfunction
`endif

  logic [ID_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
  logic                           grant_found, xfer;
  int                             grant_idx, idx;
  logic signed [DIN1_WIDTH-1:0]   a_p0_q, a_p0_d, a_p1_q;
  logic signed [DIN2_WIDTH-1:0]   b_p0_q, b_p0_d, b_p1_q;
  logic signed [P-1:0]            prod_p2_q;
  logic signed [DOUT_WIDTH-1:0]   res_p3_q, res_p3_d;
  logic [ID_WIDTH-1:0]            id_p0_q, id_p0_d, id_p1_q, id_p2_q, id_p3_q;
  logic                           vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;
`ifdef MULT_SHARE_ARBITER_SAT_EN
  logic                           sat_p3_q, sat_p3_d;
`endif

  // Arbitration: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    xfer      = grant_found & ~rst;
    req_ready = '0;
    rr_ptr_d  = rr_ptr_q;
    a_p0_d    = '0;
    b_p0_d    = '0;
    id_p0_d   = '0;
    if (xfer) begin
      req_ready = N_REQ'(1) << grant_idx;
      rr_ptr_d  = (grant_idx == N_REQ-1) ? '0 : ID_WIDTH'(grant_idx + 1);
      a_p0_d    = $signed(req_din1[DIN1_WIDTH*grant_idx +: DIN1_WIDTH]);
      b_p0_d    = $signed(req_din2[DIN2_WIDTH*grant_idx +: DIN2_WIDTH]);
      id_p0_d   = ID_WIDTH'(grant_idx);
    end
`ifdef MULT_SHARE_ARBITER_SAT_EN
    res_p3_d = sat_result(prod_p2_q);
    sat_p3_d = vld_p2_q & sat_ovf(prod_p2_q);
`else
    res_p3_d = wrap_result(prod_p2_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      a_p0_q    <= '0;
      b_p0_q    <= '0;
      id_p0_q   <= '0;
      vld_p0_q  <= 1'b0;
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      id_p1_q   <= '0;
      vld_p1_q  <= 1'b0;
      prod_p2_q <= '0;
      id_p2_q   <= '0;
      vld_p2_q  <= 1'b0;
      res_p3_q  <= '0;
      id_p3_q   <= '0;
      vld_p3_q  <= 1'b0;
`ifdef MULT_SHARE_ARBITER_SAT_EN
      sat_p3_q  <= 1'b0;
`endif
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      // p0: operand capture from the granted requester
      a_p0_q    <= a_p0_d;
      b_p0_q    <= b_p0_d;
      id_p0_q   <= id_p0_d;
      vld_p0_q  <= xfer;
      // p1: second input register
      a_p1_q    <= a_p0_q;
      b_p1_q    <= b_p0_q;
      id_p1_q   <= id_p0_q;
      vld_p1_q  <= vld_p0_q;
      // p2: full-width signed product
      prod_p2_q <= P'(a_p1_q) * P'(b_p1_q);
      id_p2_q   <= id_p1_q;
      vld_p2_q  <= vld_p1_q;
      // p3: output register after width fitting
      res_p3_q  <= res_p3_d;
      id_p3_q   <= id_p2_q;
      vld_p3_q  <= vld_p2_q;
`ifdef MULT_SHARE_ARBITER_SAT_EN
      sat_p3_q  <= sat_p3_d;
`endif
    end
  end

  assign dout       = res_p3_q;
  assign dout_valid = vld_p3_q;
  assign dout_id    = id_p3_q;
`ifdef MULT_SHARE_ARBITER_SAT_EN
  assign dout_sat   = sat_p3_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: vector table, hand-written corner sequences and a random
// phase, all checked through a scoreboard; a 24-bit-output instance covers narrow results.
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst;
  logic [63:0] req_din1;
  logic [63:0] req_din2;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready, req_ready24;
  logic signed [31:0] dout;
  logic signed [23:0] dout24;
  logic        dout_valid, dout_valid24;
  logic [1:0]  dout_id, dout_id24;
`ifdef MULT_SHARE_ARBITER_SAT_EN
  logic        dout_sat, dout_sat24;
`endif

  mult_share_arbiter u_dut (
    .clk(clk), .rst(rst), .req_din1(req_din1), .req_din2(req_din2),
    .req_valid(req_valid), .req_ready(req_ready), .dout(dout),
    .dout_valid(dout_valid), .dout_id(dout_id)
`ifdef MULT_SHARE_ARBITER_SAT_EN
    , .dout_sat(dout_sat)
`endif
  );

  mult_share_arbiter #(.DOUT_WIDTH(24)) u_dut24 (
    .clk(clk), .rst(rst), .req_din1(req_din1), .req_din2(req_din2),
    .req_valid(req_valid), .req_ready(req_ready24), .dout(dout24),
    .dout_valid(dout_valid24), .dout_id(dout_id24)
`ifdef MULT_SHARE_ARBITER_SAT_EN
    , .dout_sat(dout_sat24)
`endif
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    int          edge_n;
    logic [1:0]  id;
    logic [31:0] p32;
    logic [23:0] p24;
    logic        sat24;
  } exp_t;

  exp_t q[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   mptr   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [3:0] e);
    vec_t t;
    t.rst = r; t.valid = v; t.d1 = d1; t.d2 = d2; t.exp_ready = e;
    return t;
  endfunction

  function automatic logic [3:0] model_ready(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return 4'b0001 << ((ptr + k) % 4);
    end
    return 4'b0000;
  endfunction

  task automatic push_expect(input int g, input logic [63:0] d1, input logic [63:0] d2);
    exp_t   e;
    longint pa, pb, p;
    pa = longint'($signed(d1[16*g +: 16]));
    pb = longint'($signed(d2[16*g +: 16]));
    p  = pa * pb;
    e.edge_n = cyc + 1;
    e.id     = 2'(g);
    e.p32    = p[31:0];
    e.p24    = p[23:0];
    e.sat24  = 1'b0;
`ifdef MULT_SHARE_ARBITER_SAT_EN
    if (p > 64'sd8388607) begin
      e.p24 = 24'h7FFFFF; e.sat24 = 1'b1;
    end else if (p < -64'sd8388608) begin
      e.p24 = 24'h800000; e.sat24 = 1'b1;
    end
`endif
    q.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t e;
    if (q.size() > 0 && (cyc - q[0].edge_n) > 3) begin
      e = q.pop_front();
      chk("missing_result", 64'(cyc - e.edge_n), 64'd3);
    end
    if (dout_valid === 1'b1 || dout_valid24 === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_dout_valid", {63'd0, dout_valid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("latency", 64'(cyc - e.edge_n), 64'd3);
        chk("dout_valid24", {63'd0, dout_valid24}, 64'd1);
        chk("dout", {32'd0, dout}, {32'd0, e.p32});
        chk("dout_id", {62'd0, dout_id}, {62'd0, e.id});
        chk("dout24", {40'd0, dout24}, {40'd0, e.p24});
        chk("dout_id24", {62'd0, dout_id24}, {62'd0, e.id});
`ifdef MULT_SHARE_ARBITER_SAT_EN
        chk("dout_sat", {63'd0, dout_sat}, 64'd0);
        chk("dout_sat24", {63'd0, dout_sat24}, {63'd0, e.sat24});
`endif
      end
    end
  endtask

  // One cycle: check outputs, drive inputs, check ready, predict the transfer.
  task automatic step(input logic r, input logic [3:0] v, input logic [63:0] d1,
                      input logic [63:0] d2, input logic [3:0] e_in, input bit use_tbl);
    logic [3:0] e;
    @(negedge clk);
    check_outputs();
    rst = r; req_valid = v; req_din1 = d1; req_din2 = d2;
    if (r) q.delete();
    #1;
    e = r ? 4'b0000 : (use_tbl ? e_in : model_ready(v, mptr));
    chk("req_ready", {60'd0, req_ready}, {60'd0, e});
    chk("req_ready24", {60'd0, req_ready24}, {60'd0, e});
    for (int i = 0; i < 4; i++) begin
      if (e[i]) begin
        push_expect(i, d1, d2);
        mptr = (i + 1) % 4;
      end
    end
    if (r) mptr = 0;
  endtask

  localparam logic [63:0] D100   = {16'd100, 16'd100, 16'd100, 16'd100};
  localparam logic [63:0] D1234  = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] D3     = {48'd0, 16'd3};
  localparam logic [63:0] DM5    = {48'd0, 16'hFFFB};
  localparam logic [63:0] DMIN2  = {16'd0, 16'h8000, 32'd0};
  localparam logic [63:0] DX1    = {16'h7FFF, 32'd0, 16'h8000};
  localparam logic [63:0] DX2    = {16'h8000, 32'd0, 16'h7FFF};

  initial begin
    rst = 1'b1; req_valid = '0; req_din1 = '0; req_din2 = '0;

    step(1'b1, 4'hF, D1234, D100, 4'h0, 1'b1);
    step(1'b1, 4'hF, D1234, D100, 4'h0, 1'b1);
    @(negedge clk);
    chk("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    chk("rst_dout", {32'd0, dout}, 64'd0);
    chk("rst_dout_id", {62'd0, dout_id}, 64'd0);

    tbl.push_back(mk(1'b0, 4'b0001, D3, DM5, 4'b0001));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 4'b0000, '0, '0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, '0, '0, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b1111, D1234, D100, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b1111, D1234, D100, 4'b0010));
    tbl.push_back(mk(1'b0, 4'b1111, D1234, D100, 4'b0100));
    tbl.push_back(mk(1'b0, 4'b1111, D1234, D100, 4'b1000));
    tbl.push_back(mk(1'b0, 4'b1111, D1234, D100, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b0010, D1234, D100, 4'b0010));
    tbl.push_back(mk(1'b0, 4'b1011, D1234, D100, 4'b1000));
    tbl.push_back(mk(1'b0, 4'b1011, D1234, D100, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b1011, D1234, D100, 4'b0010));
    tbl.push_back(mk(1'b0, 4'b0001, D3, DM5, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b0001, D3, DM5, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b0100, DMIN2, DMIN2, 4'b0100));
    tbl.push_back(mk(1'b0, 4'b0000, '0, '0, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b1001, DX1, DX2, 4'b1000));
    tbl.push_back(mk(1'b0, 4'b1001, DX1, DX2, 4'b0001));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 4'b0000, '0, '0, 4'b0000));

    foreach (tbl[i]) step(tbl[i].rst, tbl[i].valid, tbl[i].d1, tbl[i].d2, tbl[i].exp_ready, 1'b1);

    // Reset mid-flight: three accepted pairs are discarded, pointer restarts at 0.
    step(1'b0, 4'b0110, D1234, D100, 4'b0010, 1'b1);
    step(1'b0, 4'b0110, D1234, D100, 4'b0100, 1'b1);
    step(1'b0, 4'b0110, D1234, D100, 4'b0010, 1'b1);
    step(1'b1, 4'b1111, D1234, D100, 4'b0000, 1'b1);
    step(1'b1, 4'b1111, D1234, D100, 4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b0000, '0, '0, 4'b0000, 1'b1);
      chk("post_rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    end
    step(1'b0, 4'b1111, D1234, D100, 4'b0001, 1'b1);

    // Random traffic with idle gaps.
    for (int i = 0; i < 1000; i++) begin
      logic [3:0]  v;
      logic [63:0] d1, d2;
      v  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) d1 = {4{16'h8000}};
      step(1'b0, v, d1, d2, 4'b0000, 1'b0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, '0, '0, 4'b0000, 1'b0);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
